cfg_loader: RTL and testbench

Configuration front end for the tiny FPGA fabric. It accepts the byte-wide bitstream from the chip pins through a valid/ready handshake and checks the sync header and CLB count. Each CLB frame is buffered whole, then replayed as a gap-free serial burst on that CLB's `cfg`/`cfg_clb_data` pair. A trailing XOR checksum is verified, and the fabric-wide `run` is released only after a clean load.

---
 rtl/cfg_loader.sv | 196 +++++++++++++++++++
 tb/tb_cfg_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_loader.sv
// cfg_loader: byte-wide configuration front end for the FPGA fabric.
// Accepts the bitstream (sync byte, CLB count, one frame per CLB, XOR checksum)
// over a valid/ready handshake, buffers each frame whole and replays it as a
// gap-free serial burst on cfg[clb]/cfg_clb_data. run is only released after
// the checksum of a complete load matches.
//
// Ports:
//   clk           - single clock
//   rst           - synchronous active-high reset
//   in_valid      - in_data holds a byte
//   in_ready      - loader accepts a byte (registered function of state)
//   in_data[7:0]  - bitstream byte
//   run_req       - host requests fabric run
//   cfg[N-1:0]    - one-hot per-CLB config enable
//   cfg_clb_data  - shared serial config bit
//   run           - fabric run enable
//   done          - load complete with good checksum
//   error         - sticky load failure (cleared only by rst)
module cfg_loader #(
    parameter int unsigned NUM_CLBS   = 4,
    parameter int unsigned FRAME_BITS = 56,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                run_req,
    output logic [NUM_CLBS-1:0] cfg,
    output logic                cfg_clb_data,
    output logic                run,
    output logic                done,
    output logic                error
);

    localparam int unsigned FRAME_BYTES = (FRAME_BITS + 7) / 8;
    localparam int unsigned BUF_W       = FRAME_BYTES * 8;
    localparam int unsigned CLB_W       = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1;
    localparam int unsigned BYTE_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned BIT_W       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CLB_W-1:0]  LAST_CLB  = CLB_W'(NUM_CLBS - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [7:0]        COUNT_VAL = 8'(NUM_CLBS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_COUNT,
        S_FILL,
        S_ARM,
        S_SHIFT,
        S_GAP,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [CLB_W-1:0]   clb_idx;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BUF_W-1:0]   frame_buf;
    logic [7:0]         csum;

    logic accept;
    logic is_sync;

    assign accept  = in_valid && in_ready;
    assign is_sync = (in_data == SYNC_BYTE);

    // Frame buffer holds byte 0 at the MSB end; serial replay shifts left so
    // bit k of the frame is MSB-first from byte 0 and LSB pad bits never leave.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            clb_idx      <= '0;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            frame_buf    <= '0;
            csum         <= '0;
            in_ready     <= 1'b0;
            cfg          <= '0;
            cfg_clb_data <= 1'b0;
            run          <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            run <= 1'b0;

            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept && is_sync) begin
                        state <= S_HDR_COUNT;
                        csum  <= '0;
                    end
                end

                S_HDR_COUNT: begin
                    if (accept) begin
                        if (in_data == COUNT_VAL) begin
                            state    <= S_FILL;
                            clb_idx  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (accept) begin
                        frame_buf <= (frame_buf << 8) | BUF_W'(in_data);
                        csum      <= csum ^ in_data;
                        if (byte_cnt == LAST_BYTE) begin
                            state        <= S_ARM;
                            in_ready     <= 1'b0;
                            cfg          <= NUM_CLBS'(1) << clb_idx;
                            cfg_clb_data <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                        end
                    end
                end

                S_ARM: begin
                    state        <= S_SHIFT;
                    bit_cnt      <= '0;
                    cfg_clb_data <= frame_buf[BUF_W-1];
                    frame_buf    <= frame_buf << 1;
                end

                S_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        state        <= S_GAP;
                        cfg          <= '0;
                        cfg_clb_data <= 1'b0;
                    end else begin
                        bit_cnt      <= bit_cnt + BIT_W'(1);
                        cfg_clb_data <= frame_buf[BUF_W-1];
                        frame_buf    <= frame_buf << 1;
                    end
                end

                S_GAP: begin
                    in_ready <= 1'b1;
                    if (clb_idx == LAST_CLB) begin
                        state <= S_CHECK;
                    end else begin
                        state    <= S_FILL;
                        clb_idx  <= clb_idx + CLB_W'(1);
                        byte_cnt <= '0;
                    end
                end

                S_CHECK: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // A new sync starts reconfiguration: run drops on the same edge.
                    if (accept && is_sync) begin
                        state <= S_HDR_COUNT;
                        done  <= 1'b0;
                        csum  <= '0;
                    end else begin
                        run <= run_req;
                    end
                end

                S_ERROR: begin
                    in_ready <= 1'b0;
                    error    <= 1'b1;
                end

                default: begin
                    state <= S_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader (NUM_CLBS=2, FRAME_BITS=12).
// Expected serial bits are queued when frame bytes are driven and popped by a
// monitor as the loader streams them out.
module tb_cfg_loader;

    localparam int unsigned NUM_CLBS   = 2;
    localparam int unsigned FRAME_BITS = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        run_req;
    logic [1:0]  cfg;
    logic        cfg_clb_data;
    logic        run;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    cfg_loader #(
        .NUM_CLBS   (NUM_CLBS),
        .FRAME_BITS (FRAME_BITS),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .run_req      (run_req),
        .cfg          (cfg),
        .cfg_clb_data (cfg_clb_data),
        .run          (run),
        .done         (done),
        .error        (error)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] cfg;
        logic       b;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] prev_cfg = 2'b00;
    int         run_len  = 0;
    int         bursts   = 0;

    localparam logic [31:0] CLEAN_FRAMES = 32'hF0A0_3C50;

    function automatic logic [7:0] xor4(input logic [31:0] f);
        return f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
    endfunction

    // Serial monitor: checks the ARM cycle, each data bit and the burst length.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_cfg = 2'b00;
            run_len  = 0;
        end else begin
            if (cfg != 2'b00) begin
                if (prev_cfg == 2'b00) begin
                    run_len = 1;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL arm_unexpected: cfg=%b with no frame pending, required cfg=00", cfg);
                    end else if (cfg !== exp_q[0].cfg || cfg_clb_data !== 1'b0) begin
                        fails++;
                        $display("FAIL arm_cycle: cfg=%b data=%b, required cfg=%b data=0",
                                 cfg, cfg_clb_data, exp_q[0].cfg);
                    end
                end else begin
                    run_len++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL shift_extra: cfg=%b data=%b beyond expected bits", cfg, cfg_clb_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({cfg, cfg_clb_data} !== {e.cfg, e.b}) begin
                            fails++;
                            $display("FAIL shift_bit: cfg=%b data=%b, required cfg=%b data=%b",
                                     cfg, cfg_clb_data, e.cfg, e.b);
                        end
                    end
                end
            end else if (prev_cfg != 2'b00) begin
                bursts++;
                tests++;
                if (run_len != int'(FRAME_BITS + 1)) begin
                    fails++;
                    $display("FAIL burst_len: %0d cycles, required %0d", run_len, FRAME_BITS + 1);
                end
            end
            prev_cfg = cfg;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Drive one byte after `gap` idle cycles; returns on the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=%b for byte %h, required 1", in_ready, b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_frame(input int clb, input logic [15:0] fw, input int gap);
        exp_t e;
        for (int k = 0; k < int'(FRAME_BITS); k++) begin
            e.cfg = 2'(1 << clb);
            e.b   = fw[15-k];
            exp_q.push_back(e);
        end
        send_byte(fw[15:8], gap);
        send_byte(fw[7:0], gap);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (cfg !== 2'(1 << clb)) begin
            fails++;
            $display("FAIL arm_latency: cfg=%b one cycle after last byte, required %b", cfg, 2'(1 << clb));
        end
    endtask

    task automatic send_load(input logic [31:0] frames, input logic [7:0] cs, input int gap);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_frame(0, frames[31:16], gap);
        send_frame(1, frames[15:0], gap);
        send_byte(cs, gap);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        run_req  = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({cfg, cfg_clb_data, in_ready, run, done, error} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: cfg=%b data=%b rdy=%b run=%b done=%b err=%b, required all 0",
                     cfg, cfg_clb_data, in_ready, run, done, error);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b after reset, required 1", in_ready);
        end
        tests++;
        if ({run, done, error, cfg} !== 5'b0) begin
            fails++;
            $display("FAIL reset_idle: run=%b done=%b err=%b cfg=%b, required 0", run, done, error, cfg);
        end
    endtask

    task automatic test_clean_load();
        int b0;
        do_reset();
        run_req = 1'b1;
        b0 = bursts;
        send_load(CLEAN_FRAMES, xor4(CLEAN_FRAMES), 0);
        tests++;
        if (done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL clean_done: done=%b error=%b, required 1/0", done, error);
        end
        tests++;
        if (run !== 1'b0) begin
            fails++;
            $display("FAIL clean_run_early: run=%b with done, required 0", run);
        end
        @(negedge clk);
        tests++;
        if (run !== 1'b1) begin
            fails++;
            $display("FAIL clean_run: run=%b, required 1", run);
        end
        tests++;
        if (bursts != b0 + 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL clean_bursts: %0d bursts, %0d bits left, required 2 and 0", bursts - b0, exp_q.size());
        end
    endtask

    task automatic test_garbage();
        int b0;
        do_reset();
        run_req = 1'b1;
        b0 = bursts;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        send_load(CLEAN_FRAMES, xor4(CLEAN_FRAMES), 0);
        tests++;
        if (done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL garbage_done: done=%b error=%b, required 1/0", done, error);
        end
        tests++;
        if (bursts != b0 + 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL garbage_bursts: %0d bursts, %0d bits left, required 2 and 0", bursts - b0, exp_q.size());
        end
    endtask

    task automatic test_bad_count();
        int b0;
        do_reset();
        b0 = bursts;
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL badcount_error: error=%b in_ready=%b, required 1/0", error, in_ready);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (cfg !== 2'b00 || bursts != b0 || error !== 1'b1) begin
            fails++;
            $display("FAIL badcount_nocfg: cfg=%b bursts=%0d error=%b, required 00/0/1", cfg, bursts - b0, error);
        end
    endtask

    task automatic test_bad_checksum();
        int b0;
        do_reset();
        run_req = 1'b1;
        b0 = bursts;
        send_load(CLEAN_FRAMES, 8'h00, 0);
        tests++;
        if (error !== 1'b1 || done !== 1'b0 || run !== 1'b0) begin
            fails++;
            $display("FAIL badsum_flags: error=%b done=%b run=%b, required 1/0/0", error, done, run);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (run !== 1'b0 || error !== 1'b1) begin
            fails++;
            $display("FAIL badsum_run: run=%b error=%b, required 0/1", run, error);
        end
        tests++;
        if (bursts != b0 + 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL badsum_bursts: %0d bursts, %0d bits left, required 2 and 0", bursts - b0, exp_q.size());
        end
    endtask

    task automatic test_bubbles();
        int          b0;
        logic [31:0] frames;
        do_reset();
        run_req = 1'b0;
        b0 = bursts;
        frames = $urandom;
        send_load(frames, xor4(frames), 5);
        tests++;
        if (done !== 1'b1 || error !== 1'b0 || run !== 1'b0) begin
            fails++;
            $display("FAIL bubbles_done: done=%b error=%b run=%b, required 1/0/0", done, error, run);
        end
        tests++;
        if (bursts != b0 + 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bubbles_bursts: %0d bursts, %0d bits left, required 2 and 0", bursts - b0, exp_q.size());
        end
    endtask

    task automatic test_reconfig_reset();
        do_reset();
        run_req = 1'b1;
        send_load(CLEAN_FRAMES, xor4(CLEAN_FRAMES), 0);
        @(negedge clk);
        tests++;
        if (run !== 1'b1) begin
            fails++;
            $display("FAIL reconfig_run_on: run=%b, required 1", run);
        end
        send_byte(8'hA5, 0);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (run !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reconfig_run_off: run=%b done=%b, required 0/0", run, done);
        end
        send_byte(8'h02, 0);
        send_frame(0, CLEAN_FRAMES[31:16], 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({cfg, cfg_clb_data, in_ready, run, done, error} !== 7'b0) begin
            fails++;
            $display("FAIL midshift_reset: cfg=%b data=%b rdy=%b run=%b done=%b err=%b, required all 0",
                     cfg, cfg_clb_data, in_ready, run, done, error);
        end
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midshift_ready: in_ready=%b, required 1", in_ready);
        end
        // 5A would be a bad count if the loader were not back in IDLE.
        send_byte(8'h5A, 0);
        send_load(CLEAN_FRAMES, xor4(CLEAN_FRAMES), 0);
        tests++;
        if (done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_load: done=%b error=%b, required 1/0", done, error);
        end
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_garbage();
        test_bad_count();
        test_bad_checksum();
        test_bubbles();
        test_reconfig_reset();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
